// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serial transmitter.
// PAR state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
  } state_e;
`endif

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);
  localparam int PAR_MAX_W = 64;

  // Zero-extension of narrower words leaves the XOR unchanged.
  function automatic logic parity_even(
    input logic [PAR_MAX_W-1:0] word
  );
    return ^word;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Load/shift register for the PISO transmitter.
// first_o is the head bit of din; next_o becomes head after one shift.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             first_o,
  output logic             next_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      if (MSB_FIRST) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign first_o = MSB_FIRST ? din[WIDTH-1]    : din[0];
  assign next_o  = MSB_FIRST ? data_q[WIDTH-2] : data_q[1];

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and frame strobe.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sframe,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sdo_q;
  logic             sdo_d;
  logic             sframe_q;
  logic             sframe_d;
  logic             done_q;
  logic             done_d;

  logic accept;
  logic last_bit;
  logic sr_shift;
  logic first_bit;
  logic next_bit;

`ifdef PISO_PARITY_EN
  logic par_q;
  logic par_d;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);

`ifdef PISO_PARITY_EN
  assign load_ready = (state_q == IDLE) || (state_q == PAR);
`else
  assign load_ready = (state_q == IDLE) || last_bit;
`endif

  assign accept   = load_valid & load_ready;
  assign sr_shift = (state_q == SHIFT) && (cnt_q != '0);

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sreg (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .shift   (sr_shift),
    .din     (din),
    .first_o (first_bit),
    .next_o  (next_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sdo_d    = 1'b0;
    sframe_d = 1'b0;
    done_d   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    if (accept) begin
      // First bit goes straight to sdo; the register feeds the rest.
      state_d  = SHIFT;
      cnt_d    = CNT_MAX;
      sdo_d    = first_bit;
      sframe_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d    = parity_even(PAR_MAX_W'(din));
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_d    = cnt_q - 1'b1;
            sdo_d    = next_bit;
            sframe_d = 1'b1;
`ifndef PISO_PARITY_EN
            done_d   = (cnt_q == CNT_W'(1));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d  = PAR;
            sdo_d    = par_q;
            sframe_d = 1'b1;
            done_d   = 1'b1;
`else
            state_d  = IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sdo_q    <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sdo_q    <= sdo_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign sdo    = sdo_q;
  assign sframe = sframe_q;
  assign done   = done_q;

endmodule
